// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the temp register micro-sequencer:
// opcodes, instruction field positions, FSM state type and an operand helper.
package temp_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_BRZ  = 3'd4;
  localparam logic [2:0] OP_BRN  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam int unsigned OPC_HI = 7;
  localparam int unsigned OPC_LO = 5;
  localparam int unsigned OPR_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  // LDI operand is a signed 5-bit immediate widened to the register width.
  function automatic logic [7:0] sext_operand(input logic [OPR_W-1:0] opr);
    return {{(8 - OPR_W){opr[OPR_W-1]}}, opr};
  endfunction

endpackage

// File: rtl/temp_ctrl_sequencer_decoder.sv
// Combinational instruction decoder for temp_ctrl_sequencer.
// Ports:
//   imem_rdata        in  8  instruction word (opcode [7:5], operand [4:0])
//   negative/positive/zero in 1 temp register flags
//   do_load/do_inc/do_dec out 1 register action requested by the instruction
//   load_value        out 8  sign-extended LDI immediate
//   branch_taken      out 1  BRZ/BRN condition met, or JMP
//   is_halt           out 1  HALT instruction
module temp_ctrl_decoder
  import temp_ctrl_pkg::*;
(
  input  logic [7:0] imem_rdata,
  input  logic       negative,
  input  logic       positive,
  input  logic       zero,
  output logic       do_load,
  output logic       do_inc,
  output logic       do_dec,
  output logic [7:0] load_value,
  output logic       branch_taken,
  output logic       is_halt
);

  logic [2:0]       opcode;
  logic [OPR_W-1:0] operand;
  // No instruction branches on the positive flag; it is carried for completeness.
  logic             unused_positive;

  assign opcode          = imem_rdata[OPC_HI:OPC_LO];
  assign operand         = imem_rdata[OPR_W-1:0];
  assign load_value      = sext_operand(operand);
  assign unused_positive = positive;

  always_comb begin
    do_load      = 1'b0;
    do_inc       = 1'b0;
    do_dec       = 1'b0;
    branch_taken = 1'b0;
    is_halt      = 1'b0;
    case (opcode)
      OP_LDI:  do_load      = 1'b1;
      OP_INC:  do_inc       = 1'b1;
      OP_DEC:  do_dec       = 1'b1;
      OP_BRZ:  branch_taken = zero;
      OP_BRN:  branch_taken = negative;
      OP_JMP:  branch_taken = 1'b1;
      OP_HALT: is_halt      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/temp_ctrl_sequencer.sv
// Micro-sequencer driving the 8-bit temp register from a synchronous ROM.
// Each instruction takes FETCH + EXEC; register pulses issue at the end of
// EXEC and are high for the following FETCH cycle only.
// Optional: `define SINGLE_STEP_EN adds a step input that gates FETCH->EXEC.
// Ports:
//   clk, reset_n (async active-low), start (restart from pc=0 in IDLE/HALTED)
//   imem_addr [PC_W-1:0] out = pc; imem_rdata [7:0] in, one cycle latency
//   negative/positive/zero in flags; load/increment/decrement out pulses
//   data [7:0] out load value (holds when load=0); busy, halted out status
module temp_ctrl_sequencer
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  input  logic            negative,
  input  logic            positive,
  input  logic            zero,
  output logic            load,
  output logic            increment,
  output logic            decrement,
  output logic [7:0]      data,
  output logic            busy,
  output logic            halted
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            load_nxt, inc_nxt, dec_nxt;
  logic [7:0]      data_nxt;
  logic            fetch_go;

  logic            do_load, do_inc, do_dec, branch_taken, is_halt;
  logic [7:0]      load_value;

  temp_ctrl_decoder u_decoder (
    .imem_rdata   (imem_rdata),
    .negative     (negative),
    .positive     (positive),
    .zero         (zero),
    .do_load      (do_load),
    .do_inc       (do_inc),
    .do_dec       (do_dec),
    .load_value   (load_value),
    .branch_taken (branch_taken),
    .is_halt      (is_halt)
  );

`ifdef SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_nxt  = 1'b0;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    data_nxt  = data;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        if (fetch_go) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_halt) begin
          state_nxt = S_HALTED;
        end else begin
          state_nxt = S_FETCH;
          pc_nxt    = branch_taken ? imem_rdata[PC_W-1:0] : pc + PC_W'(1);
          load_nxt  = do_load;
          inc_nxt   = do_inc;
          dec_nxt   = do_dec;
          if (do_load) data_nxt = load_value;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      load      <= 1'b0;
      increment <= 1'b0;
      decrement <= 1'b0;
      data      <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      load      <= load_nxt;
      increment <= inc_nxt;
      decrement <= dec_nxt;
      data      <= data_nxt;
    end
  end

  assign imem_addr = pc;
  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_temp_ctrl_sequencer.sv
module tb_temp_ctrl_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic [4:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       negative, positive, zero;
  logic       load, increment, decrement, busy, halted;
  logic [7:0] data;
`ifdef SINGLE_STEP_EN
  logic       step  = 1'b1;
  logic       step2 = 1'b1;
`endif

  // second instance for PC wrap with a 2-bit counter and an all-NOP ROM
  logic       start2 = 1'b0;
  logic [1:0] imem_addr2;
  logic [7:0] rdata2 = 8'h00;
  logic       flag0 = 1'b0;
  logic       load2, inc2, dec2, busy2, halted2;
  logic [7:0] data2;

  temp_ctrl_sequencer #(.PC_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .negative(negative), .positive(positive), .zero(zero),
    .load(load), .increment(increment), .decrement(decrement),
    .data(data), .busy(busy), .halted(halted)
  );

  temp_ctrl_sequencer #(.PC_W(2)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start2),
`ifdef SINGLE_STEP_EN
    .step(step2),
`endif
    .imem_addr(imem_addr2), .imem_rdata(rdata2),
    .negative(flag0), .positive(flag0), .zero(flag0),
    .load(load2), .increment(inc2), .decrement(dec2),
    .data(data2), .busy(busy2), .halted(halted2)
  );

  // environment: synchronous ROM and the temp register it controls
  logic [7:0] rom [32];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  logic [7:0] tv = 8'd0;
  always @(posedge clk) begin
    if (load)           tv <= data;
    else if (increment) tv <= tv + 8'd1;
    else if (decrement) tv <= tv - 8'd1;
  end
  assign zero     = (tv == 8'd0);
  assign negative = tv[7];
  assign positive = !tv[7] && (tv != 8'd0);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // observations from the last program run
  int         n_instr;
  int         n_dec;
  bit         halted_seen;
  logic [7:0] load_q [$];
  int         fetch_q [$];

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
  endtask

  task automatic abort_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Instruction-level reference: walks the program from pc=0 with its own copy
  // of the register value, and checks the DUT at each FETCH/EXEC half.
  task automatic run_prog(input int max_instr);
    logic [4:0] pc;
    logic [7:0] t, ins, imm, pdata;
    logic [4:0] opr;
    int         kind, pkind;
    bit         taken;
    n_instr = 0; n_dec = 0; halted_seen = 0;
    load_q.delete(); fetch_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = tv; pc = 5'd0; pkind = 0; pdata = 8'h00;
    for (int i = 0; i < max_instr; i++) begin
      check("fetch_busy", busy, 1);
      check("fetch_addr", imem_addr, pc);
      check("fetch_load", load, pkind == 1);
      check("fetch_inc", increment, pkind == 2);
      check("fetch_dec", decrement, pkind == 3);
      if (load) load_q.push_back(data);
      if (pkind == 1) check("fetch_data", data, pdata);
      if (decrement) n_dec++;
      fetch_q.push_back(int'(pc));
      n_instr++;
      @(negedge clk);
      check("exec_busy", busy, 1);
      check("exec_pulses", {load, increment, decrement}, 0);
      ins = rom[pc]; opr = ins[4:0]; imm = {{3{opr[4]}}, opr};
      kind = 0; taken = 0;
      case (ins[7:5])
        3'd1: begin kind = 1; t = imm; pdata = imm; end
        3'd2: begin kind = 2; t = t + 8'd1; end
        3'd3: begin kind = 3; t = t - 8'd1; end
        3'd4: taken = (t == 8'd0);
        3'd5: taken = t[7];
        3'd6: taken = 1;
        default: ;
      endcase
      if (ins[7:5] == 3'd7) begin
        @(negedge clk);
        check("halt_flag", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_pulses", {load, increment, decrement}, 0);
        check("halt_addr", imem_addr, pc);
        halted_seen = 1;
        return;
      end
      pc = taken ? opr : pc + 5'd1;
      pkind = kind;
      @(negedge clk);
    end
    abort_reset();
  endtask

  initial begin
    clear_rom();
    // reset state
    #2;
    check("rst_pulses", {load, increment, decrement}, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", imem_addr, 0);
    @(negedge clk); reset_n = 1'b1;

    // asynchronous reset in the middle of EXEC
    rom[0] = 8'h25; rom[1] = 8'h40; rom[2] = 8'hE0;   // LDI 5, INC, HALT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;                      // FETCH 0
    @(negedge clk);                                    // EXEC 0
    @(negedge clk);                                    // FETCH 1
    check("pre_load", load, 1);
    @(negedge clk);                                    // EXEC 1
    check("pre_data", data, 8'h05);
    check("pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_data", data, 0);
    check("arst_pulses", {load, increment, decrement}, 0);
    check("arst_busy", busy, 0);
    check("arst_halted", halted, 0);
    check("arst_addr", imem_addr, 0);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_addr", imem_addr, 0);
      check("idle_busy", busy, 0);
    end

    // countdown: LDI 3, DEC, BRZ 4, JMP 1, HALT
    clear_rom();
    rom[0] = 8'h23; rom[1] = 8'h60; rom[2] = 8'h84; rom[3] = 8'hC1; rom[4] = 8'hE0;
    run_prog(50);
    check("cd_halted", halted_seen, 1);
    check("cd_ndec", n_dec, 3);
    check("cd_ninstr", n_instr, 10);

    // LDI sign extension
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'h2F; rom[2] = 8'hE0;
    run_prog(10);
    check("ldi_count", load_q.size(), 2);
    if (load_q.size() == 2) begin
      check("ldi_neg", load_q[0], 8'hF0);
      check("ldi_pos", load_q[1], 8'h0F);
    end

    // BRN taken at -1, not taken after INC to 0
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'hA3; rom[2] = 8'hE0; rom[3] = 8'h40;
    rom[4] = 8'hA6; rom[5] = 8'hE0; rom[6] = 8'hE0;
    run_prog(10);
    check("brn_len", fetch_q.size(), 5);
    if (fetch_q.size() == 5) begin
      check("brn_taken", fetch_q[2], 3);
      check("brn_fall", fetch_q[4], 5);
    end

    // randomized programs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
      run_prog(40);
    end

    // PC wrap on the 2-bit instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wrap_addr", imem_addr2, i % 4);
      check("wrap_pulses", {load2, inc2, dec2}, 0);
      @(negedge clk);
      check("wrap_exec_pulses", {load2, inc2, dec2}, 0);
      @(negedge clk);
    end

`ifdef SINGLE_STEP_EN
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'hE0;                    // INC, HALT
    step = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_addr", imem_addr, 0);
      check("hold_busy", busy, 1);
      check("hold_pulses", {load, increment, decrement}, 0);
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk); step = 1'b0;                       // EXEC of INC
    check("step_exec_pulses", {load, increment, decrement}, 0);
    @(negedge clk);                                    // held FETCH 1
    check("step_inc", increment, 1);
    check("step_addr", imem_addr, 1);
    @(negedge clk);
    check("step_inc_clear", increment, 0);
    check("step_hold_addr", imem_addr, 1);
    check("step_hold_busy", busy, 1);
    step = 1'b1;
    @(negedge clk); @(negedge clk);
    check("step_halted", halted, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
